vga_fb_scanout: RTL

VGA_FB_SCANOUT -- requirements
Module: vga_fb_scanout

---
 rtl/vga_fb_scanout.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vga_fb_scanout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_fb_scanout                                                |
// | Purpose  : 640x480@60 VGA timing generator that scans an 8x8 monochrome  |
// |            framebuffer.                                                  |
// |            - Each cell is 80x60 screen pixels.                           |
// |            - A shadow copy of the image is taken at the start of         |
// |              vertical blanking, so the displayed frame never tears.      |
// | Ports    : clock        - single rising-edge clock                       |
// |            reset        - asynchronous, active-low reset                 |
// |            framebuffer  - 64-bit image, bit index = row*8 + col          |
// |            vga_hsync    - horizontal sync, active low, registered        |
// |            vga_vsync    - vertical sync, active low, registered          |
// |            vga_r/g/b    - pixel colour (all equal), registered           |
// | Params   : CLKDIV       - clock cycles per pixel, legal range 1..15      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vga_fb_scanout #(
  parameter int CLKDIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] framebuffer,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b
);

  // Horizontal timing (pixels)
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd751;
  localparam logic [9:0] H_LAST       = 10'd799;
  // Vertical timing (lines)
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd491;
  localparam logic [9:0] V_LAST       = 10'd524;
  // Cell geometry: 640/8 = 80 pixels wide, 480/8 = 60 lines high
  localparam logic [6:0] COL_SUB_LAST = 7'd79;
  localparam logic [5:0] ROW_SUB_LAST = 6'd59;
  localparam logic [3:0] PRESC_LAST   = 4'(CLKDIV - 1);

  logic [3:0]  presc_q,   presc_d;
  logic [9:0]  h_q,       h_d;
  logic [9:0]  v_q,       v_d;
  logic [2:0]  col_q,     col_d;
  logic [6:0]  col_sub_q, col_sub_d;
  logic [2:0]  row_q,     row_d;
  logic [5:0]  row_sub_q, row_sub_d;
  logic [63:0] shadow_q,  shadow_d;
  logic        hsync_q,   hsync_d;
  logic        vsync_q,   vsync_d;
  logic        pixel_q,   pixel_d;

  logic tick;
  logic h_wrap;
  logic v_wrap;
  logic visible;

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    h_wrap  = (h_q == H_LAST);
    v_wrap  = (v_q == V_LAST);
    visible = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);

    presc_d   = tick ? 4'd0 : presc_q + 4'd1;
    h_d       = h_q;
    v_d       = v_q;
    col_d     = col_q;
    col_sub_d = col_sub_q;
    row_d     = row_q;
    row_sub_d = row_sub_q;
    shadow_d  = shadow_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    pixel_d   = pixel_q;

    if (tick) begin
      h_d = h_wrap ? 10'd0 : h_q + 10'd1;

      // Column tracking replaces h/80. The column keeps counting through
      // blanking (wrapping harmlessly); it is realigned when h wraps.
      if (h_wrap) begin
        col_d     = 3'd0;
        col_sub_d = 7'd0;
      end else if (col_sub_q == COL_SUB_LAST) begin
        col_d     = col_q + 3'd1;
        col_sub_d = 7'd0;
      end else begin
        col_sub_d = col_sub_q + 7'd1;
      end

      // Row tracking replaces v/60 and only moves at end of line.
      if (h_wrap) begin
        v_d = v_wrap ? 10'd0 : v_q + 10'd1;
        if (v_wrap) begin
          row_d     = 3'd0;
          row_sub_d = 6'd0;
        end else if (row_sub_q == ROW_SUB_LAST) begin
          row_d     = row_q + 3'd1;
          row_sub_d = 6'd0;
        end else begin
          row_sub_d = row_sub_q + 6'd1;
        end
      end

      // Snapshot the image at the first pixel of vertical blanking so
      // framebuffer writes during a visible frame never show mid-frame.
      if ((h_q == 10'd0) && (v_q == V_VISIBLE)) begin
        shadow_d = framebuffer;
      end

      // Outputs describe the (h,v) the counters hold during this tick.
      hsync_d = !((h_q >= H_SYNC_START) && (h_q <= H_SYNC_END));
      vsync_d = !((v_q >= V_SYNC_START) && (v_q <= V_SYNC_END));
      pixel_d = visible & shadow_q[{row_q, col_q}];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q   <= 4'd0;
      h_q       <= 10'd0;
      v_q       <= 10'd0;
      col_q     <= 3'd0;
      col_sub_q <= 7'd0;
      row_q     <= 3'd0;
      row_sub_q <= 6'd0;
      shadow_q  <= 64'd0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      pixel_q   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      h_q       <= h_d;
      v_q       <= v_d;
      col_q     <= col_d;
      col_sub_q <= col_sub_d;
      row_q     <= row_d;
      row_sub_q <= row_sub_d;
      shadow_q  <= shadow_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      pixel_q   <= pixel_d;
    end
  end

  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign vga_r     = pixel_q;
  assign vga_g     = pixel_q;
  assign vga_b     = pixel_q;

endmodule
`default_nettype wire
